// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - merges CH1/CH2/SHARE config write strobes into one valid/ready port
// Per-source FIFOs absorb sink stalls; a round-robin arbiter fills a single registered output slot.
module cfg_write_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic          CLK_LOW,
   input  logic          RST_N,
   input  logic          CH1_CONFIG_WE,
   input  logic [AW-1:0] CH1_CONFIG_ADDR,
   input  logic [DW-1:0] CH1_CONFIG_DATA,
   input  logic          CH2_CONFIG_WE,
   input  logic [AW-1:0] CH2_CONFIG_ADDR,
   input  logic [DW-1:0] CH2_CONFIG_DATA,
   input  logic          SHARE_CONFIG_WE,
   input  logic [AW-1:0] SHARE_CONFIG_ADDR,
   input  logic [DW-1:0] SHARE_CONFIG_DATA,
   output logic          CFG_VALID,
   input  logic          CFG_READY,
   output logic [1:0]    CFG_SRC,
   output logic [AW-1:0] CFG_ADDR,
   output logic [DW-1:0] CFG_DATA,
   output logic [2:0]    OVF_FLAGS,
   input  logic          OVF_CLR,
   output logic          BUSY
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + DW;

   logic [EW-1:0] mem [3][DEPTH];
   logic [PW-1:0] wr_ptr [3];
   logic [PW-1:0] rd_ptr [3];
   logic [CW-1:0] count [3];
   logic [EW-1:0] wr_word [3];
   logic [EW-1:0] head;
   logic [2:0]    we, full, nonempty, push, pop, drop;
   logic [1:0]    last, gnt;
   logic          gnt_valid, slot_free;

   function automatic logic [1:0] rr_pick(input logic [1:0] after, input int offset);
      int s;
      s = (int'(after) + offset) % 3;
      return 2'(s);
   endfunction

   assign we         = {SHARE_CONFIG_WE, CH2_CONFIG_WE, CH1_CONFIG_WE};
   assign wr_word[0] = {CH1_CONFIG_ADDR, CH1_CONFIG_DATA};
   assign wr_word[1] = {CH2_CONFIG_ADDR, CH2_CONFIG_DATA};
   assign wr_word[2] = {SHARE_CONFIG_ADDR, SHARE_CONFIG_DATA};

   always_comb begin
      full     = '0;
      nonempty = '0;
      for (int i = 0; i < 3; i++) begin
         full[i]     = (count[i] == CW'(DEPTH));
         nonempty[i] = (count[i] != '0);
      end
   end

   // Full is judged on the pre-edge count, so a push onto a full FIFO is dropped even if it pops.
   assign push      = we & ~full;
   assign drop      = we & full;
   assign slot_free = !CFG_VALID || CFG_READY;

   // Scan from farthest to nearest so the nearest non-empty source after "last" wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt       = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         if (nonempty[rr_pick(last, k)]) begin
            gnt_valid = 1'b1;
            gnt       = rr_pick(last, k);
         end
      end
   end

   assign pop  = (slot_free && gnt_valid) ? (3'b001 << gnt) : 3'b000;
   assign head = mem[gnt][rd_ptr[gnt]];

   always_ff @(posedge CLK_LOW) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= wr_word[i];
      end
   end

   always_ff @(posedge CLK_LOW or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
         end
      end
   end

   always_ff @(posedge CLK_LOW or negedge RST_N) begin
      if (!RST_N) begin
         CFG_VALID <= 1'b0;
         CFG_SRC   <= 2'd0;
         CFG_ADDR  <= '0;
         CFG_DATA  <= '0;
         last      <= 2'd2;
         OVF_FLAGS <= 3'b000;
      end else begin
         if (slot_free) begin
            if (gnt_valid) begin
               CFG_VALID            <= 1'b1;
               CFG_SRC              <= gnt;
               {CFG_ADDR, CFG_DATA} <= head;
               last                 <= gnt;
            end else begin
               CFG_VALID <= 1'b0;
            end
         end
         // A drop in the same cycle as a clear still leaves its flag set.
         OVF_FLAGS <= (OVF_CLR ? 3'b000 : OVF_FLAGS) | drop;
      end
   end

   assign BUSY = (|nonempty) || CFG_VALID;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - directed self-checking bench for cfg_write_arbiter
module tb_cfg_write_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ch1_we, ch2_we, share_we;
   logic [7:0] ch1_addr, ch1_data, ch2_addr, ch2_data, share_addr, share_data;
   logic       cfg_valid, cfg_ready;
   logic [1:0] cfg_src;
   logic [7:0] cfg_addr, cfg_data;
   logic [2:0] ovf_flags;
   logic       ovf_clr, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cfg_write_arbiter #(.DEPTH(4), .AW(8), .DW(8)) dut (
      .CLK_LOW          (clk),
      .RST_N            (rst_n),
      .CH1_CONFIG_WE    (ch1_we),
      .CH1_CONFIG_ADDR  (ch1_addr),
      .CH1_CONFIG_DATA  (ch1_data),
      .CH2_CONFIG_WE    (ch2_we),
      .CH2_CONFIG_ADDR  (ch2_addr),
      .CH2_CONFIG_DATA  (ch2_data),
      .SHARE_CONFIG_WE  (share_we),
      .SHARE_CONFIG_ADDR(share_addr),
      .SHARE_CONFIG_DATA(share_data),
      .CFG_VALID        (cfg_valid),
      .CFG_READY        (cfg_ready),
      .CFG_SRC          (cfg_src),
      .CFG_ADDR         (cfg_addr),
      .CFG_DATA         (cfg_data),
      .OVF_FLAGS        (ovf_flags),
      .OVF_CLR          (ovf_clr),
      .BUSY             (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ch1_we = 1'b0;   ch1_addr = 8'h00;   ch1_data = 8'h00;
      ch2_we = 1'b0;   ch2_addr = 8'h00;   ch2_data = 8'h00;
      share_we = 1'b0; share_addr = 8'h00; share_data = 8'h00;
      ovf_clr = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      cfg_ready = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cfg_valid); end
      total++; if (cfg_src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", cfg_src); end
      total++; if ({cfg_addr, cfg_data} !== 16'h0000) begin bad++; $display("FAIL reset_payload got=%h exp=0000", {cfg_addr, cfg_data}); end
      total++; if (ovf_flags !== 3'b000) begin bad++; $display("FAIL reset_ovf got=%b exp=000", ovf_flags); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      apply_reset();
      cfg_ready = 1'b1;
      ch1_we = 1'b1; ch1_addr = 8'h12; ch1_data = 8'hA5;
      step();
      clear_inputs();
      total++; if (cfg_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_lat1 got valid=%b busy=%b exp valid=0 busy=1", cfg_valid, busy); end
      step();
      total++; if ({cfg_valid, cfg_src, cfg_addr, cfg_data} !== {1'b1, 2'd0, 8'h12, 8'hA5})
         begin bad++; $display("FAIL single_word got v=%b s=%0d a=%h d=%h exp v=1 s=0 a=12 d=a5", cfg_valid, cfg_src, cfg_addr, cfg_data); end
      step();
      total++; if (cfg_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after got valid=%b busy=%b exp 0 0", cfg_valid, busy); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      cfg_ready = 1'b1;
      ch1_we = 1'b1;   ch1_addr = 8'h10;   ch1_data = 8'h01;
      ch2_we = 1'b1;   ch2_addr = 8'h20;   ch2_data = 8'h02;
      share_we = 1'b1; share_addr = 8'h30; share_data = 8'h03;
      step();
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if ({cfg_valid, cfg_src, cfg_addr, cfg_data} !== {1'b1, 2'(i), 8'(16 * (i + 1)), 8'(i + 1)})
            begin bad++; $display("FAIL simul_word%0d got v=%b s=%0d a=%h d=%h exp v=1 s=%0d d=%0d", i, cfg_valid, cfg_src, cfg_addr, cfg_data, i, i + 1); end
      end
      step();
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL simul_end got valid=%b exp=0", cfg_valid); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      ch1_we = 1'b1; ch1_addr = 8'h31; ch1_data = 8'h5A;
      ch2_we = 1'b1; ch2_addr = 8'h32; ch2_data = 8'h6B;
      step();
      clear_inputs();
      step();
      for (int i = 0; i < 10; i++) begin
         total++; if ({cfg_valid, cfg_src, cfg_addr, cfg_data} !== {1'b1, 2'd0, 8'h31, 8'h5A})
            begin bad++; $display("FAIL bp_hold%0d got v=%b s=%0d a=%h d=%h exp v=1 s=0 a=31 d=5a", i, cfg_valid, cfg_src, cfg_addr, cfg_data); end
         step();
      end
      cfg_ready = 1'b1;
      total++; if ({cfg_valid, cfg_src, cfg_data} !== {1'b1, 2'd0, 8'h5A}) begin bad++; $display("FAIL bp_first got v=%b s=%0d d=%h exp 1 0 5a", cfg_valid, cfg_src, cfg_data); end
      step();
      total++; if ({cfg_valid, cfg_src, cfg_addr, cfg_data} !== {1'b1, 2'd1, 8'h32, 8'h6B})
         begin bad++; $display("FAIL bp_second got v=%b s=%0d a=%h d=%h exp 1 1 32 6b", cfg_valid, cfg_src, cfg_addr, cfg_data); end
      step();
      total++; if (cfg_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_nodup got valid=%b busy=%b exp 0 0", cfg_valid, busy); end
   endtask

   task automatic test_overflow();
      int cyc;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         ch2_we = 1'b1; ch2_addr = 8'(8'h40 + i); ch2_data = 8'(i);
         step();
      end
      clear_inputs();
      total++; if (ovf_flags !== 3'b010) begin bad++; $display("FAIL ovf_set got=%b exp=010", ovf_flags); end
      cfg_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++; if ({cfg_valid, cfg_src, cfg_data} !== {1'b1, 2'd1, 8'(i)})
            begin bad++; $display("FAIL ovf_drain%0d got v=%b s=%0d d=%0d exp v=1 s=1 d=%0d", i, cfg_valid, cfg_src, cfg_data, i); end
         step();
      end
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL ovf_dropped got valid=%b d=%0d exp valid=0", cfg_valid, cfg_data); end
      total++; if (ovf_flags !== 3'b010) begin bad++; $display("FAIL ovf_sticky got=%b exp=010", ovf_flags); end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      total++; if (ovf_flags !== 3'b000) begin bad++; $display("FAIL ovf_clear got=%b exp=000", ovf_flags); end
      cfg_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ch2_we = 1'b1; ch2_data = 8'(8'h80 + i);
         step();
      end
      total++; if (ovf_flags !== 3'b000) begin bad++; $display("FAIL ovf_fill got=%b exp=000", ovf_flags); end
      ch2_data = 8'h85; ovf_clr = 1'b1;
      step();
      clear_inputs();
      total++; if (ovf_flags !== 3'b010) begin bad++; $display("FAIL ovf_clr_vs_set got=%b exp=010", ovf_flags); end
      cfg_ready = 1'b1;
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_drain_timeout got busy=%b after %0d cycles exp 0", busy, cyc); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_src [8];
      logic [7:0] exp_data [8];
      exp_src  = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      exp_data = '{8'hC0, 8'hE0, 8'hC1, 8'hE1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      apply_reset();
      cfg_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         ch1_we = (c < 6);   ch1_addr = 8'h10;   ch1_data = 8'(8'hC0 + c);
         share_we = (c < 2); share_addr = 8'h30; share_data = 8'(8'hE0 + c);
         step();
         if (c >= 1) begin
            total++; if ({cfg_valid, cfg_src, cfg_data} !== {1'b1, exp_src[c-1], exp_data[c-1]})
               begin bad++; $display("FAIL fair%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", c - 1, cfg_valid, cfg_src, cfg_data, exp_src[c-1], exp_data[c-1]); end
         end
      end
      clear_inputs();
      step();
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL fair_end got valid=%b exp=0", cfg_valid); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      ch1_we = 1'b1;   ch1_data = 8'h11;
      ch2_we = 1'b1;   ch2_data = 8'h22;
      share_we = 1'b1; share_data = 8'h33;
      step();
      clear_inputs();
      step();
      total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL mid_loaded got valid=%b exp=1", cfg_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (cfg_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got valid=%b busy=%b exp 0 0", cfg_valid, busy); end
      step();
      rst_n = 1'b1;
      cfg_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL mid_stale%0d got valid=%b d=%h exp valid=0", i, cfg_valid, cfg_data); end
      end
      ch1_we = 1'b1; ch1_addr = 8'h77; ch1_data = 8'h99;
      step();
      clear_inputs();
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL mid_lat1 got valid=%b exp=0", cfg_valid); end
      step();
      total++; if ({cfg_valid, cfg_src, cfg_addr, cfg_data} !== {1'b1, 2'd0, 8'h77, 8'h99})
         begin bad++; $display("FAIL mid_next got v=%b s=%0d a=%h d=%h exp 1 0 77 99", cfg_valid, cfg_src, cfg_addr, cfg_data); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      cfg_ready = 1'b0;
      clear_inputs();
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_overflow();
      test_fairness();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
